// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port registered-read RAM.
// Port 0 is the SPI command FSM, port 1 the pattern/self-test engine. A locking
// requester may hold the RAM for up to BURST_MAX consecutive grants while the
// other port waits. Read data is routed back to the issuing port two cycles
// after its access.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_MAX = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic              i_we0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic              i_lock0,
  input  logic              i_req1,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  input  logic              i_lock1,
  output logic              o_gnt0,
  output logic              o_rvalid0,
  output logic [DATA_W-1:0] o_rdata0,
  output logic              o_gnt1,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic              o_owner
);

  localparam int unsigned CntW = $clog2(BURST_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(BURST_MAX);

  typedef enum logic {StIdle, StAccess} state_e;

  state_e            state_q, state_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              owner_q, owner_d;
  // last_q resets to 1 so that port 0 wins the first contested grant.
  logic              last_q, last_d;
  logic              last_lock_q, last_lock_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // Read-tag pipeline: stage 1 while RAM data is in flight, stage 2 is the rvalid cycle.
  logic              tag_vld_q, tag_vld_d;
  logic              tag_port_q, tag_port_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic [1:0]        req, lock;
  logic              win;
  logic              win_we, win_lock;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  assign req  = {i_req1, i_req0};
  assign lock = {i_lock1, i_lock0};

  // Winner selection: lone requester, then locked burst continuation, else round robin.
  always_comb begin
    win = ~last_q;
    if (i_req0 && !i_req1) begin
      win = 1'b0;
    end else if (i_req1 && !i_req0) begin
      win = 1'b1;
    end else if (last_lock_q && lock[last_q] && (cnt_q < CntMax)) begin
      win = last_q;
    end
    win_we    = win ? i_we1    : i_we0;
    win_lock  = lock[win];
    win_addr  = win ? i_addr1  : i_addr0;
    win_wdata = win ? i_wdata1 : i_wdata0;
  end

  // Access FSM next state, registered RAM command and burst bookkeeping.
  always_comb begin
    state_d     = state_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    gnt_d       = 2'b00;
    owner_d     = owner_q;
    last_d      = last_q;
    last_lock_d = last_lock_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d     = StAccess;
          mem_en_d    = 1'b1;
          mem_we_d    = win_we;
          addr_d      = win_addr;
          wdata_d     = win_wdata;
          gnt_d[win]  = 1'b1;
          owner_d     = win;
          last_d      = win;
          last_lock_d = win_lock;
          if (!win_lock) begin
            cnt_d = '0;
          end else if ((win == last_q) && last_lock_q) begin
            cnt_d = (cnt_q < CntMax) ? cnt_q + 1'b1 : cnt_q;
          end else begin
            cnt_d = CntW'(1);
          end
        end
      end
      StAccess: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Read return routing: tag a read access, then capture RAM data for its port.
  always_comb begin
    tag_vld_d  = (state_q == StAccess) && !mem_we_q;
    tag_port_d = owner_q;
    rvalid0_d  = tag_vld_q && !tag_port_q;
    rvalid1_d  = tag_vld_q && tag_port_q;
    rdata0_d   = rvalid0_d ? i_mem_rdata : rdata0_q;
    rdata1_d   = rvalid1_d ? i_mem_rdata : rdata1_q;
  end

  // State registers; reset drops any in-flight read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      gnt_q       <= 2'b00;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      last_lock_q <= 1'b0;
      cnt_q       <= '0;
      tag_vld_q   <= 1'b0;
      tag_port_q  <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      last_lock_q <= last_lock_d;
      cnt_q       <= cnt_d;
      tag_vld_q   <= tag_vld_d;
      tag_port_q  <= tag_port_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign o_gnt0      = gnt_q[0];
  assign o_gnt1      = gnt_q[1];
  assign o_rvalid0   = rvalid0_q;
  assign o_rvalid1   = rvalid1_q;
  assign o_rdata0    = rdata0_q;
  assign o_rdata1    = rdata1_q;
  assign o_mem_en    = mem_en_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_owner     = owner_q;
  assign o_busy      = (state_q == StAccess) | tag_vld_q | rvalid0_q | rvalid1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level reference model
// predicts grants, RAM commands and routed read returns every cycle.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 15;
  localparam int unsigned DW   = 8;
  localparam int unsigned BMAX = 4;
  localparam int unsigned MEMN = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req [2];
  logic          we [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic          lock [2];

  logic          o_gnt0, o_gnt1, o_rvalid0, o_rvalid1;
  logic [DW-1:0] o_rdata0, o_rdata1;
  logic          o_mem_en, o_mem_we, o_busy, o_owner;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] ram  [MEMN];
  logic [DW-1:0] mref [MEMN];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BMAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req[0]), .i_we0(we[0]), .i_addr0(addr[0]), .i_wdata0(wdata[0]), .i_lock0(lock[0]),
    .i_req1(req[1]), .i_we1(we[1]), .i_addr1(addr[1]), .i_wdata1(wdata[1]), .i_lock1(lock[1]),
    .o_gnt0(o_gnt0), .o_rvalid0(o_rvalid0), .o_rdata0(o_rdata0),
    .o_gnt1(o_gnt1), .o_rvalid1(o_rvalid1), .o_rdata1(o_rdata1),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata),
    .o_busy(o_busy), .o_owner(o_owner)
  );

  // Registered-read RAM behind the arbiter.
  always @(posedge clk) begin
    if (o_mem_en) begin
      if (o_mem_we) ram[o_mem_addr] <= o_mem_wdata;
      else          mem_rdata <= ram[o_mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: expected outputs for the cycle after each clock edge.
  typedef struct {int due; bit port; logic [DW-1:0] data;} rd_t;
  rd_t           rq[$];
  int            cyc;
  bit            m_access;   // the cycle after this edge is an access cycle
  bit            m_last;     // port granted most recently
  bit            m_last_lk;  // that grant was locked
  int            m_run;      // length of the current locked run by m_last
  bit [1:0]      e_gnt, e_rv;
  bit            e_en, e_we, e_owner, e_busy;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [DW-1:0] e_rdata [2];

  task automatic model_reset();
    m_access = 0; m_last = 1; m_last_lk = 0; m_run = 0;
    e_gnt = 0; e_rv = 0; e_en = 0; e_we = 0; e_owner = 0; e_busy = 0;
    e_addr = '0; e_wdata = '0; e_rdata[0] = '0; e_rdata[1] = '0;
    rq.delete();
  endtask

  task automatic model_step();
    bit w;
    cyc++;
    e_gnt = 0; e_rv = 0; e_en = 0; e_we = 0;
    if (!m_access && (req[0] || req[1])) begin
      if (req[0] && !req[1])      w = 0;
      else if (req[1] && !req[0]) w = 1;
      else if (m_last_lk && lock[m_last] && m_run < int'(BMAX)) w = m_last;
      else                        w = !m_last;
      if (!lock[w])                 m_run = 0;
      else if (w == m_last && m_last_lk) m_run = (m_run < int'(BMAX)) ? m_run + 1 : m_run;
      else                          m_run = 1;
      m_last = w; m_last_lk = lock[w];
      e_gnt[w] = 1; e_en = 1; e_we = we[w]; e_owner = w;
      e_addr = addr[w]; e_wdata = wdata[w];
      if (we[w]) mref[addr[w]] = wdata[w];
      else       rq.push_back('{due: cyc + 2, port: w, data: mref[addr[w]]});
      m_access = 1;
    end else begin
      m_access = 0;
    end
    e_busy = m_access || (rq.size() > 0);
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e_rv[rq[0].port] = 1;
      e_rdata[rq[0].port] = rq[0].data;
      void'(rq.pop_front());
    end
  endtask

  task automatic compare_all();
    check_eq("gnt0", o_gnt0, e_gnt[0]);
    check_eq("gnt1", o_gnt1, e_gnt[1]);
    check_eq("mem_en", o_mem_en, e_en);
    check_eq("mem_we", o_mem_we, e_we);
    check_eq("mem_addr", o_mem_addr, e_addr);
    check_eq("mem_wdata", o_mem_wdata, e_wdata);
    check_eq("owner", o_owner, e_owner);
    check_eq("rvalid0", o_rvalid0, e_rv[0]);
    check_eq("rvalid1", o_rvalid1, e_rv[1]);
    check_eq("rdata0", o_rdata0, e_rdata[0]);
    check_eq("rdata1", o_rdata1, e_rdata[1]);
    check_eq("busy", o_busy, e_busy);
  endtask

  task automatic new_cmd(input int p);
    req[p]   = 1;
    we[p]    = ($urandom_range(0, 2) == 0);
    addr[p]  = ($urandom_range(0, 9) == 0) ? AW'(15'h7FFF) : AW'($urandom_range(0, 7));
    wdata[p] = DW'($urandom);
  endtask

  task automatic drive_random();
    for (int p = 0; p < 2; p++) begin
      if (req[p] && !e_gnt[p]) begin
        if ($urandom_range(0, 19) == 0) req[p] = 0;
      end else begin
        if ($urandom_range(0, 7) == 0) lock[p] = ~lock[p];
        if ($urandom_range(0, 9) < 7) new_cmd(p);
        else req[p] = 0;
      end
    end
  endtask

  logic [46:0] all_out;
  assign all_out = {o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1, o_mem_en,
                    o_mem_we, o_mem_addr, o_mem_wdata, o_busy, o_owner};

  initial begin
    logic [9:0] seq;
    int         ng;
    bit         reset_done;
    for (int i = 0; i < int'(MEMN); i++) begin
      ram[i]  = DW'($urandom);
      mref[i] = ram[i];
    end
    for (int p = 0; p < 2; p++) begin
      req[p] = 0; we[p] = 0; addr[p] = '0; wdata[p] = '0; lock[p] = 0;
    end
    model_reset();
    cyc = 0;
    #1;
    check_eq("reset_outputs", all_out, 47'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Both ports contend, port 0 locked: burst of BMAX, then one port-1 grant.
    new_cmd(0); new_cmd(1);
    lock[0] = 1; lock[1] = 0;
    seq = '0; ng = 0;
    for (int i = 0; i < 22; i++) begin
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      if ((o_gnt0 || o_gnt1) && ng < 10) begin
        seq[ng] = o_gnt1;
        ng++;
      end
      for (int p = 0; p < 2; p++) if (e_gnt[p]) new_cmd(p);
    end
    check_eq("burst_grant_count", ng, 10);
    check_eq("burst_grant_order", seq, 10'b1000010000);

    // Random traffic with one asynchronous reset landing during a read.
    lock[0] = 0;
    reset_done = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      if (!reset_done && i >= 1500 && e_gnt[0] && !e_we) begin
        reset_done = 1;
        #2 rst_n = 0;
        #1 check_eq("async_reset_outputs", all_out, 47'd0);
        repeat (2) @(posedge clk);
        #1 check_eq("held_reset_outputs", all_out, 47'd0);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        new_cmd(0); new_cmd(1);
        lock[0] = 0; lock[1] = 0;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        check_eq("post_reset_first_gnt0", o_gnt0, 1'b1);
      end
      drive_random();
    end
    check_eq("reset_exercised", reset_done, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
